round_display_bcd_seq: RTL and testbench
========================================

// Module: round_display_bcd_seq
// PURPOSE
//  Sequential, parametrised successor to the 3-digit round-number display. Accepts an
//  unsigned binary value on a load strobe, converts it to BCD with a multi-cycle
//  double-dabble engine, and drives DIGITS active-low 7-segment digits. Adds
//  leading-zero blanking, out-of-range dash display, a blink mode and busy/done status.
//  Sits between the game-control FSM (round counter) and the board HEX displays.
// PARAMETERS
//  IN_W      8    width of binary input value
//  DIGITS    3    number of 7-seg digits driven; digit 0 = ones
//  MAX_VAL   100  largest value displayed; any larger value shows all dashes
//  BLINK_DIV 25   clk cycles per blink half-period (>=1)
// PORTS
//  clk       in   1           system clock, rising edge
//  rst_n     in   1           async active-low reset
//  load      in   1           pulse: capture value and blank_lz (accepted only when busy=0)
//  value     in   IN_W        unsigned binary value to display
//  blank_lz  in   1           1 = blank leading zeros (sampled with load)
//  blink_en  in   1           1 = flash the whole display (live, not sampled)
//  busy      out  1           1 while a conversion is in progress
//  done      out  1           one-cycle pulse when seg takes a new value
//  seg       out  DIGITS x 7  seg[d][0:6] = segments a..g of digit d, active-low
// BEHAVIOUR
//  Encoding [0:6]=a..g, 0=lit: 0=0000001 1=1001111 2=0010010 3=0000110 4=1001100
//   5=0100100 6=0100000 7=0001111 8=0000000 9=0001100 dash=1111110 blank=1111111.
//  Reset (async, rst_n=0): state IDLE, busy=0, done=0, every digit shows "0" (0000001),
//   blink phase=lit, blink counter=0; conversion in flight is discarded.
//  FSM: IDLE -> CONV -> UPDT -> IDLE.
//   IDLE: load=1 -> latch value, blank_lz, ovf=(value>MAX_VAL); clear BCD reg
//         (4*DIGITS bits) and carry flag; step=0; -> CONV. busy=1 from next cycle.
//   CONV: exactly IN_W cycles; per cycle: +3 to every BCD nibble >=5, then shift
//         {carry,BCD,bin} left 1; carry is sticky (any 1 shifted out of top nibble).
//   UPDT: one cycle; registered seg updated atomically; done=1; busy=0 next cycle.
//  Latency: load sampled at edge N -> new seg and done visible after edge N+IN_W+1.
//  load while busy=1 is ignored (no queueing); load in UPDT cycle also ignored.
//  seg never shows partial conversion results; holds previous frame while busy.
//  Display rules at UPDT (priority order):
//   1. ovf=1 or carry=1 -> all digits dash.
//   2. else digit d = BCD nibble d; if blank_lz, digits above the most significant
//      nonzero digit are blank; digit 0 always shown (value 0 -> blank..blank,"0").
//  Blink: counter runs continuously; phase toggles every BLINK_DIV cycles. While
//   blink_en=1 and phase=off, seg = all blank; else seg = stored frame. blink_en=0
//   forces lit output but counter keeps running. Blink applies to dashes too.
//  done asserted exactly one cycle per accepted load; never when seg is not updated.
//  All outputs registered; no combinational path from inputs to seg except blink gating
//   from registered phase and blink_en.
// TESTING
//  1 Reset mid-CONV (load 57 then rst_n=0 at cycle 3) -> busy=0, done=0, seg=0,0,0;
//    no done pulse after release.
//  2 Defaults, load value=42 blank_lz=0 -> busy for 8 cycles, done at cycle 9;
//    seg[2..0]=0000001,1001100,0010010.
//  3 load 100 -> "1","0","0"; load 101 -> all 1111110; load 255 -> all 1111110.
//  4 blank_lz=1: load 7 -> 1111111,1111111,0001111; load 0 -> blank,blank,0000001;
//    load 30 -> blank,0000110,0000001.
//  5 load 42, then load 99 pulsed at cycles 2 and UPDT -> ignored; seg stays 42,
//    exactly one done pulse.
//  6 IN_W=10, DIGITS=3, MAX_VAL=1023: load 999 -> 9,9,9; load 1000 -> dashes via
//    carry. Blink: blink_en=1, BLINK_DIV=4 -> seg alternates frame/blank every 4 cycles.

Source files
------------

// File: rtl/round_display_bcd_seq.sv
// Loads a binary value and converts it to BCD one bit per cycle (double-dabble).
// Drives active-low 7-segment digits with leading-zero blanking, overflow dashes and blink.

module rbs_digit (
  input  logic [3:0] nib,
  input  logic       dash,
  input  logic       blank,
  output logic [0:6] seg
);
  always_comb begin
    seg = 7'b1111110;
    if (dash)       seg = 7'b1111110;
    else if (blank) seg = 7'b1111111;
    else begin
      case (nib)
        4'd0:    seg = 7'b0000001;
        4'd1:    seg = 7'b1001111;
        4'd2:    seg = 7'b0010010;
        4'd3:    seg = 7'b0000110;
        4'd4:    seg = 7'b1001100;
        4'd5:    seg = 7'b0100100;
        4'd6:    seg = 7'b0100000;
        4'd7:    seg = 7'b0001111;
        4'd8:    seg = 7'b0000000;
        4'd9:    seg = 7'b0001100;
        default: seg = 7'b1111110;
      endcase
    end
  end
endmodule

module round_display_bcd_seq #(
  parameter int IN_W      = 8,
  parameter int DIGITS    = 3,
  parameter int MAX_VAL   = 100,
  parameter int BLINK_DIV = 25
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load,
  input  logic [IN_W-1:0]          value,
  input  logic                     blank_lz,
  input  logic                     blink_en,
  output logic                     busy,
  output logic                     done,
  output logic [DIGITS-1:0][0:6]   seg
);
  localparam int BW = 4*DIGITS;
  localparam int SW = $clog2(IN_W+1);
  localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [SW-1:0] LAST_STEP = SW'(IN_W-1);
  localparam logic [CW-1:0] LAST_CNT  = CW'(BLINK_DIV-1);
  localparam logic [31:0]   MAXV      = MAX_VAL;
  localparam logic [0:6]    SEG_ZERO  = 7'b0000001;

  typedef enum logic [1:0] {IDLE, CONV, UPDT} state_t;

  state_t                 state;
  logic [IN_W-1:0]        bin;
  logic [BW-1:0]          bcd, adj;
  logic                   carry, ovf, blz;
  logic [SW-1:0]          step;
  logic [DIGITS-1:0][0:6] frame, nxt;
  logic [DIGITS:1]        lead;
  logic [DIGITS-1:0]      blk;
  logic [CW-1:0]          bcnt;
  logic                   phase;

  // lead[d]: every nibble from d upward is zero, so digit d is a leading zero
  assign lead[DIGITS] = 1'b1;

  for (genvar d = 0; d < DIGITS; d++) begin : g_dig
    assign adj[4*d +: 4] = (bcd[4*d +: 4] >= 4'd5) ? bcd[4*d +: 4] + 4'd3 : bcd[4*d +: 4];
    if (d > 0) begin : g_lz
      assign lead[d] = lead[d+1] && (bcd[4*d +: 4] == 4'd0);
      assign blk[d]  = blz & lead[d];
    end else begin : g_one
      assign blk[d]  = 1'b0;
    end
    rbs_digit u_dig (
      .nib   (bcd[4*d +: 4]),
      .dash  (ovf | carry),
      .blank (blk[d]),
      .seg   (nxt[d])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      bin   <= '0;
      bcd   <= '0;
      carry <= 1'b0;
      ovf   <= 1'b0;
      blz   <= 1'b0;
      step  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      frame <= {DIGITS{SEG_ZERO}};
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (load) begin
          bin   <= value;
          blz   <= blank_lz;
          ovf   <= 32'(value) > MAXV;
          bcd   <= '0;
          carry <= 1'b0;
          step  <= '0;
          busy  <= 1'b1;
          state <= CONV;
        end
        CONV: begin
          // carry is sticky: any digit overflow means the value exceeds DIGITS
          bcd   <= {adj[BW-2:0], bin[IN_W-1]};
          bin   <= bin << 1;
          carry <= carry | adj[BW-1];
          step  <= step + 1'b1;
          if (step == LAST_STEP) state <= UPDT;
        end
        UPDT: begin
          frame <= nxt;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt  <= '0;
      phase <= 1'b0;
    end else if (bcnt == LAST_CNT) begin
      bcnt  <= '0;
      phase <= ~phase;
    end else begin
      bcnt  <= bcnt + 1'b1;
    end
  end

  assign seg = (blink_en && phase) ? '1 : frame;
endmodule

// File: tb/tb_round_display_bcd_seq.sv
// Randomised and directed checks of round_display_bcd_seq against a decimal-arithmetic model.

module tb_round_display_bcd_seq;
  typedef logic [2:0][0:6] frame_t;

  localparam logic [6:0] ENC [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                     7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                     7'b0000000, 7'b0001100};
  localparam logic [6:0] DASH  = 7'b1111110;
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [20:0] ZERO_F = {3{7'b0000001}};
  localparam logic [20:0] DASH_F = {3{7'b1111110}};

  logic clk = 1'b0, rst_n = 1'b0;
  logic la = 0, bza = 0, bea = 0, busy_a, done_a;
  logic [7:0] va = '0;
  frame_t seg_a;
  logic lb = 0, bzb = 0, beb = 0, busy_b, done_b;
  logic [9:0] vb = '0;
  frame_t seg_b;

  int errors = 0, checks = 0;
  int ecnt;

  always #5 clk = ~clk;

  // edges since reset release; blink phase follows from this directly
  always @(posedge clk or negedge rst_n)
    if (!rst_n) ecnt <= 0; else ecnt <= ecnt + 1;

  round_display_bcd_seq u_a (
    .clk(clk), .rst_n(rst_n), .load(la), .value(va), .blank_lz(bza), .blink_en(bea),
    .busy(busy_a), .done(done_a), .seg(seg_a));

  round_display_bcd_seq #(.IN_W(10), .DIGITS(3), .MAX_VAL(1023), .BLINK_DIV(4)) u_b (
    .clk(clk), .rst_n(rst_n), .load(lb), .value(vb), .blank_lz(bzb), .blink_en(beb),
    .busy(busy_b), .done(done_b), .seg(seg_b));

  function automatic frame_t model(input int v, input bit blz, input int maxv);
    frame_t f;
    int dg;
    if (v > maxv || v > 999) return DASH_F;
    for (int d = 0; d < 3; d++) begin
      dg = (v / (10**d)) % 10;
      f[d] = ENC[dg];
      if (blz && d > 0 && v < 10**d) f[d] = BLANK;
    end
    return f;
  endfunction

  // Drives one load and reports what the DUT did; comparisons happen in the callers.
  task automatic run_conv(input bit sel_b, input int v, input bit blz,
                          output int dcyc, output bit busy_ok, output bit done_once,
                          output frame_t s);
    @(posedge clk); #1;
    if (sel_b) begin lb = 1; vb = v[9:0]; bzb = blz; end
    else       begin la = 1; va = v[7:0]; bza = blz; end
    @(posedge clk); #1;
    la = 0; lb = 0;
    dcyc = -1;
    busy_ok = sel_b ? busy_b : busy_a;
    s = sel_b ? seg_b : seg_a;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (sel_b ? done_b : done_a) begin
        dcyc = k;
        s = sel_b ? seg_b : seg_a;
        if (sel_b ? busy_b : busy_a) busy_ok = 0;
        break;
      end
      if (!(sel_b ? busy_b : busy_a)) busy_ok = 0;
    end
    @(posedge clk); #1;
    done_once = !(sel_b ? done_b : done_a);
  endtask

  task automatic test_reset();
    int dn;
    bit bz;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy_a !== 1'b0 || done_a !== 1'b0 || seg_a !== ZERO_F || seg_b !== ZERO_F) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b seg_a=%h seg_b=%h want 0 0 %h", busy_a, done_a, seg_a, seg_b, ZERO_F);
    end
    @(posedge clk); #1 rst_n = 1;
    @(posedge clk); #1 la = 1; va = 8'd57; bza = 0;
    @(posedge clk); #1 la = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy_a !== 1'b1) begin errors++; $display("FAIL reset_pre_busy: busy=%b want 1", busy_a); end
    rst_n = 0;
    #1;
    checks++;
    if (busy_a !== 1'b0 || done_a !== 1'b0 || seg_a !== ZERO_F) begin
      errors++;
      $display("FAIL reset_mid_conv: busy=%b done=%b seg=%h want 0 0 %h", busy_a, done_a, seg_a, ZERO_F);
    end
    @(posedge clk); #1 rst_n = 1;
    dn = 0; bz = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done_a) dn++;
      if (busy_a) bz = 1;
    end
    checks++;
    if (dn !== 0 || bz !== 0 || seg_a !== ZERO_F) begin
      errors++;
      $display("FAIL reset_no_done: dones=%0d busy_seen=%b seg=%h want 0 0 %h", dn, bz, seg_a, ZERO_F);
    end
  endtask

  task automatic test_basic();
    int dc; bit bok, d1; frame_t s;
    run_conv(0, 42, 0, dc, bok, d1, s);
    checks++;
    if (dc !== 9 || !bok || !d1) begin
      errors++;
      $display("FAIL basic_timing: done_cycle=%0d busy_ok=%b single=%b want 9 1 1", dc, bok, d1);
    end
    checks++;
    if (s !== {7'b0000001, 7'b1001100, 7'b0010010}) begin
      errors++;
      $display("FAIL basic_42: seg=%h want %h", s, {7'b0000001, 7'b1001100, 7'b0010010});
    end
  endtask

  task automatic test_range();
    int vals[3] = '{100, 101, 255};
    int dc; bit bok, d1; frame_t s;
    foreach (vals[i]) begin
      run_conv(0, vals[i], 0, dc, bok, d1, s);
      checks++;
      if (s !== model(vals[i], 0, 100) || dc !== 9) begin
        errors++;
        $display("FAIL range_%0d: seg=%h cyc=%0d want %h 9", vals[i], s, dc, model(vals[i], 0, 100));
      end
    end
  endtask

  task automatic test_blank();
    int vals[3] = '{7, 0, 30};
    int dc; bit bok, d1; frame_t s;
    foreach (vals[i]) begin
      run_conv(0, vals[i], 1, dc, bok, d1, s);
      checks++;
      if (s !== model(vals[i], 1, 100) || dc !== 9 || !bok) begin
        errors++;
        $display("FAIL blank_%0d: seg=%h cyc=%0d busy_ok=%b want %h 9 1", vals[i], s, dc, bok, model(vals[i], 1, 100));
      end
    end
  endtask

  task automatic test_random();
    int v, dc; bit b, bok, d1; frame_t s;
    repeat (16) begin
      v = $urandom_range(0, 255);
      b = 1'($urandom_range(0, 1));
      run_conv(0, v, b, dc, bok, d1, s);
      checks++;
      if (s !== model(v, b, 100) || dc !== 9 || !bok || !d1) begin
        errors++;
        $display("FAIL random_%0d_lz%0d: seg=%h cyc=%0d busy_ok=%b single=%b want %h 9 1 1", v, b, s, dc, bok, d1, model(v, b, 100));
      end
    end
  endtask

  task automatic test_back_to_back();
    int dn;
    @(posedge clk); #1 la = 1; va = 8'd42; bza = 0;
    @(posedge clk); #1 la = 0;
    @(posedge clk); #1;
    @(posedge clk); #1 la = 1; va = 8'd99;
    checks++;
    if (busy_a !== 1'b1) begin errors++; $display("FAIL ignore_busy: busy=%b want 1", busy_a); end
    @(posedge clk); #1 la = 0;
    repeat (5) @(posedge clk);
    #1 la = 1; va = 8'd99;
    dn = 0;
    @(posedge clk); #1 la = 0;
    checks++;
    if (done_a !== 1'b1) begin errors++; $display("FAIL ignore_done_edge: done=%b want 1", done_a); end
    if (done_a) dn++;
    repeat (20) begin
      @(posedge clk); #1;
      if (done_a) dn++;
    end
    checks++;
    if (dn !== 1 || seg_a !== model(42, 0, 100) || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL ignore_result: dones=%0d seg=%h busy=%b want 1 %h 0", dn, seg_a, busy_a, model(42, 0, 100));
    end
  endtask

  task automatic test_wide();
    int vals[8];
    int dc; bit bok, d1; frame_t s;
    vals[0] = 999; vals[1] = 1000;
    for (int i = 2; i < 8; i++) vals[i] = $urandom_range(0, 1023);
    foreach (vals[i]) begin
      run_conv(1, vals[i], 0, dc, bok, d1, s);
      checks++;
      if (s !== model(vals[i], 0, 1023) || dc !== 11 || !bok || !d1) begin
        errors++;
        $display("FAIL wide_%0d: seg=%h cyc=%0d busy_ok=%b single=%b want %h 11 1 1", vals[i], s, dc, bok, d1, model(vals[i], 0, 1023));
      end
    end
  endtask

  task automatic test_blink();
    int dc; bit bok, d1; frame_t s, fr, exp;
    int vals[2] = '{123, 1000};
    foreach (vals[i]) begin
      run_conv(1, vals[i], 0, dc, bok, d1, s);
      fr = model(vals[i], 0, 1023);
      @(posedge clk); #1 beb = 1;
      for (int k = 0; k < 12; k++) begin
        @(posedge clk); #1;
        exp = ((ecnt / 4) % 2) ? '1 : fr;
        checks++;
        if (seg_b !== exp) begin
          errors++;
          $display("FAIL blink_%0d_c%0d: seg=%h want %h", vals[i], k, seg_b, exp);
        end
      end
      beb = 0;
      for (int k = 0; k < 6; k++) begin
        @(posedge clk); #1;
        checks++;
        if (seg_b !== fr) begin
          errors++;
          $display("FAIL blink_off_%0d_c%0d: seg=%h want %h", vals[i], k, seg_b, fr);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_range();
    test_blank();
    test_random();
    test_back_to_back();
    test_wide();
    test_blink();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
